// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
// The requester side drives req; the arbiter drives the registered grant fields.
interface rr_grant_arbiter_if #(
    parameter int NUM_REQ   = 8,
    parameter int IDX_WIDTH = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   gnt;
    logic [IDX_WIDTH-1:0] gnt_idx;
    logic                 gnt_valid;
    logic                 timeout;

    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output timeout
    );
endinterface

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with registered one-hot grant, binary index,
// bounded tenure and a timeout pulse when a tenure is cut short.
module rr_grant_arbiter #(
    parameter int NUM_REQ    = 8,
    parameter int IDX_WIDTH  = $clog2(NUM_REQ),
    parameter int MAX_HOLD   = 16,
    parameter int HOLD_WIDTH = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    rr_grant_arbiter_if.slave bus
);
    localparam int CW = IDX_WIDTH + 1;
    localparam logic [CW-1:0]         NUM_W    = CW'(NUM_REQ);
    localparam logic [IDX_WIDTH-1:0]  IDX_ONE  = 1;
    localparam logic [IDX_WIDTH-1:0]  IDX_LAST = IDX_WIDTH'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0]    OH_ONE   = 1;
    localparam logic [HOLD_WIDTH-1:0] HOLD_ONE = 1;
    localparam logic [HOLD_WIDTH-1:0] HOLD_SAT =
        (MAX_HOLD == 0) ? {HOLD_WIDTH{1'b1}} : HOLD_WIDTH'(MAX_HOLD);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e               state_q;
    logic [IDX_WIDTH-1:0] ptr_q;
    logic [HOLD_WIDTH-1:0] hold_q;
    logic [NUM_REQ-1:0]   gnt_q;
    logic [IDX_WIDTH-1:0] idx_q;
    logic                 valid_q;
    logic                 timeout_q;

    logic                 win_found;
    logic [IDX_WIDTH-1:0] win_idx;
    logic [NUM_REQ-1:0]   win_oh;
    logic [CW-1:0]        cand;
    logic                 owner_req;
    logic                 limit_hit;
    logic                 release_w;

    // Scan ptr, ptr+1, ... wrapping at NUM_REQ (not at 2**IDX_WIDTH),
    // so unused index codes are never selected for non-power-of-2 sizes.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + CW'(i);
            if (cand >= NUM_W) begin
                cand = cand - NUM_W;
            end
            if (!win_found && bus.req[cand[IDX_WIDTH-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_WIDTH-1:0];
            end
        end
    end

    assign win_oh    = OH_ONE << win_idx;
    assign owner_req = bus.req[idx_q];
    assign limit_hit = (MAX_HOLD != 0) && (hold_q == HOLD_SAT);
    assign release_w = !owner_req || limit_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            hold_q    <= '0;
            gnt_q     <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    timeout_q <= 1'b0;
                    if (win_found) begin
                        state_q <= GRANT;
                        gnt_q   <= win_oh;
                        idx_q   <= win_idx;
                        valid_q <= 1'b1;
                        hold_q  <= HOLD_ONE;
                    end
                end
                GRANT: begin
                    if (release_w) begin
                        state_q   <= IDLE;
                        gnt_q     <= '0;
                        valid_q   <= 1'b0;
                        hold_q    <= '0;
                        ptr_q     <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_ONE;
                        // Only a forced revoke pulses; a voluntary drop does not.
                        timeout_q <= limit_hit && owner_req;
                    end else begin
                        timeout_q <= 1'b0;
                        if (hold_q != HOLD_SAT) begin
                            hold_q <= hold_q + HOLD_ONE;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = valid_q;
    assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter: vector table plus hand sequences
// over three configurations (8/16, 8/4 and 5/16).
module tb_rr_grant_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rr_grant_arbiter_if #(.NUM_REQ(8)) a_if ();
    rr_grant_arbiter_if #(.NUM_REQ(8)) b_if ();
    rr_grant_arbiter_if #(.NUM_REQ(5)) c_if ();

    rr_grant_arbiter #(.NUM_REQ(8), .MAX_HOLD(16)) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if)
    );
    rr_grant_arbiter #(.NUM_REQ(8), .MAX_HOLD(4)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if)
    );
    rr_grant_arbiter #(.NUM_REQ(5), .MAX_HOLD(16)) u_c (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (c_if)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       to;
    } vec_t;

    vec_t tv[16];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string n, input logic [7:0] g,
                         input logic [2:0] i, input logic v, input logic t);
        chk({n, ".gnt"}, 32'(a_if.gnt), 32'(g));
        chk({n, ".idx"}, 32'(a_if.gnt_idx), 32'(i));
        chk({n, ".valid"}, 32'(a_if.gnt_valid), 32'(v));
        chk({n, ".to"}, 32'(a_if.timeout), 32'(t));
    endtask

    task automatic chk_b(input string n, input logic [7:0] g,
                         input logic [2:0] i, input logic v, input logic t);
        chk({n, ".gnt"}, 32'(b_if.gnt), 32'(g));
        chk({n, ".idx"}, 32'(b_if.gnt_idx), 32'(i));
        chk({n, ".valid"}, 32'(b_if.gnt_valid), 32'(v));
        chk({n, ".to"}, 32'(b_if.timeout), 32'(t));
    endtask

    task automatic chk_c(input string n, input logic [4:0] g,
                         input logic [2:0] i, input logic v);
        chk({n, ".gnt"}, 32'(c_if.gnt), 32'(g));
        chk({n, ".idx"}, 32'(c_if.gnt_idx), 32'(i));
        chk({n, ".valid"}, 32'(c_if.gnt_valid), 32'(v));
    endtask

    task automatic do_reset();
        a_if.req = '0;
        b_if.req = '0;
        c_if.req = '0;
        rst_n = 1'b0;
        #12;
        chk_a("rst_a", 8'h00, 3'd0, 1'b0, 1'b0);
        chk_b("rst_b", 8'h00, 3'd0, 1'b0, 1'b0);
        chk_c("rst_c", 5'h00, 3'd0, 1'b0);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bit_w;
        int ph;

        tv[0]  = '{8'h04, 8'h04, 3'd2, 1'b1, 1'b0};
        tv[1]  = '{8'h04, 8'h04, 3'd2, 1'b1, 1'b0};
        tv[2]  = '{8'h04, 8'h04, 3'd2, 1'b1, 1'b0};
        tv[3]  = '{8'h04, 8'h04, 3'd2, 1'b1, 1'b0};
        tv[4]  = '{8'h04, 8'h04, 3'd2, 1'b1, 1'b0};
        tv[5]  = '{8'h00, 8'h00, 3'd2, 1'b0, 1'b0};
        tv[6]  = '{8'h05, 8'h01, 3'd0, 1'b1, 1'b0};
        tv[7]  = '{8'h04, 8'h00, 3'd0, 1'b0, 1'b0};
        tv[8]  = '{8'h04, 8'h04, 3'd2, 1'b1, 1'b0};
        tv[9]  = '{8'h00, 8'h00, 3'd2, 1'b0, 1'b0};
        tv[10] = '{8'h00, 8'h00, 3'd2, 1'b0, 1'b0};
        tv[11] = '{8'h04, 8'h04, 3'd2, 1'b1, 1'b0};
        tv[12] = '{8'h0C, 8'h04, 3'd2, 1'b1, 1'b0};
        tv[13] = '{8'h08, 8'h00, 3'd2, 1'b0, 1'b0};
        tv[14] = '{8'h08, 8'h08, 3'd3, 1'b1, 1'b0};
        tv[15] = '{8'h00, 8'h00, 3'd3, 1'b0, 1'b0};

        do_reset();

        // Single requester, pointer advance, owner drop vs new request
        for (int i = 0; i < 16; i++) begin
            a_if.req = tv[i].req;
            tick();
            chk_a($sformatf("vec%0d", i), tv[i].gnt, tv[i].idx,
                  tv[i].valid, tv[i].to);
        end

        // Rotation: each owner keeps 2 cycles then drops for one edge
        do_reset();
        for (int k = 0; k < 9; k++) begin
            bit_w = 8'h01 << (k % 8);
            a_if.req = 8'hFF;
            tick();
            chk_a($sformatf("rot%0d_g1", k), bit_w, 3'(k % 8), 1'b1, 1'b0);
            tick();
            chk_a($sformatf("rot%0d_g2", k), bit_w, 3'(k % 8), 1'b1, 1'b0);
            a_if.req = 8'hFF & ~bit_w;
            tick();
            chk_a($sformatf("rot%0d_idle", k), 8'h00, 3'(k % 8), 1'b0, 1'b0);
        end

        // Default tenure limit of 16
        do_reset();
        a_if.req = 8'h02;
        for (int n = 0; n < 18; n++) begin
            tick();
            if (n == 16)
                chk_a($sformatf("h16_%0d", n), 8'h00, 3'd1, 1'b0, 1'b1);
            else
                chk_a($sformatf("h16_%0d", n), 8'h02, 3'd1, 1'b1, 1'b0);
        end

        // MAX_HOLD=4, sole requester: period 5 with timeout pulse
        do_reset();
        b_if.req = 8'h01;
        for (int n = 0; n < 15; n++) begin
            tick();
            ph = n % 5;
            if (ph < 4)
                chk_b($sformatf("h4_%0d", n), 8'h01, 3'd0, 1'b1, 1'b0);
            else
                chk_b($sformatf("h4_%0d", n), 8'h00, 3'd0, 1'b0, 1'b1);
        end

        // MAX_HOLD=4, two competitors alternate 0 and 7
        do_reset();
        b_if.req = 8'h81;
        for (int n = 0; n < 20; n++) begin
            tick();
            ph = n % 10;
            if (ph < 4)
                chk_b($sformatf("alt_%0d", n), 8'h01, 3'd0, 1'b1, 1'b0);
            else if (ph == 4)
                chk_b($sformatf("alt_%0d", n), 8'h00, 3'd0, 1'b0, 1'b1);
            else if (ph < 9)
                chk_b($sformatf("alt_%0d", n), 8'h80, 3'd7, 1'b1, 1'b0);
            else
                chk_b($sformatf("alt_%0d", n), 8'h00, 3'd7, 1'b0, 1'b1);
        end

        // NUM_REQ=5 pointer wrap from 4 back to 0
        do_reset();
        c_if.req = 5'b01000;
        tick();
        chk_c("w5_g3", 5'b01000, 3'd3, 1'b1);
        c_if.req = 5'b00000;
        tick();
        chk_c("w5_rel3", 5'b00000, 3'd3, 1'b0);
        c_if.req = 5'b00011;
        tick();
        chk_c("w5_g0", 5'b00001, 3'd0, 1'b1);
        chk("w5_noX", 32'($isunknown(c_if.gnt_idx)), 32'd0);
        c_if.req = 5'b00010;
        tick();
        chk_c("w5_rel0", 5'b00000, 3'd0, 1'b0);
        tick();
        chk_c("w5_g1", 5'b00010, 3'd1, 1'b1);
        c_if.req = 5'b00000;
        tick();
        chk_c("w5_rel1", 5'b00000, 3'd1, 1'b0);

        // Async reset mid-grant; pointer left at 6 beforehand
        do_reset();
        a_if.req = 8'h20;
        tick();
        a_if.req = 8'h00;
        tick();
        chk_a("ar_pre", 8'h00, 3'd5, 1'b0, 1'b0);
        a_if.req = 8'h20;
        tick();
        tick();
        tick();
        chk_a("ar_hold3", 8'h20, 3'd5, 1'b1, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk_a("ar_async", 8'h00, 3'd0, 1'b0, 1'b0);
        a_if.req = 8'hA0;
        tick();
        chk_a("ar_inrst", 8'h00, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_a("ar_first", 8'h20, 3'd5, 1'b1, 1'b0);
        a_if.req = 8'h00;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
